// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Shares the write port of one synchronous FWFT FIFO between N packet
// producers. Arbitration is round-robin at packet granularity: once a
// requester is granted it keeps the FIFO until its last word is written.
// Each packet costs one arbitration cycle in IDLE before its first word.
//
// Parameters:
//   N        number of requesters (2..16)
//   D_WIDTH  data word width
//   TIMEOUT  idle cycles mid-packet before the grant is revoked
//            (only used when FIFO_ARB_TIMEOUT_EN is defined)
//
// Ports:
//   clk          clock, all logic on rising edge
//   rst_n        asynchronous reset, active-low
//   req_valid    per-requester word valid
//   req_last     per-requester last-word-of-packet flag
//   req_data     packed words, slice i = [i*D_WIDTH +: D_WIDTH]
//   req_ready    per-requester accept (word taken when valid & ready)
//   fifo_din     data to FIFO
//   fifo_wr_en   write enable to FIFO
//   fifo_full    FIFO full flag
//   grant_id     current / most recently granted requester
//   busy         high while a packet transfer is in progress
//   timeout_err  one-cycle pulse when a stalled grant is revoked
//                (port exists only with FIFO_ARB_TIMEOUT_EN)
//
// Optional feature macro: FIFO_ARB_TIMEOUT_EN enables the mid-packet
// idle timeout and the timeout_err output.

module fifo_wr_arbiter #(
    parameter int N       = 4,
    parameter int D_WIDTH = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           req_valid,
    input  logic [N-1:0]           req_last,
    input  logic [N*D_WIDTH-1:0]   req_data,
    output logic [N-1:0]           req_ready,
    output logic [D_WIDTH-1:0]     fifo_din,
    output logic                   fifo_wr_en,
    input  logic                   fifo_full,
    output logic [$clog2(N)-1:0]   grant_id,
    output logic                   busy
`ifdef FIFO_ARB_TIMEOUT_EN
    ,
    output logic                   timeout_err
`endif
);

    localparam int GW = $clog2(N);

    if (N < 2 || N > 16 || TIMEOUT < 1) begin : g_param_check
        $error("fifo_wr_arbiter: N must be 2..16 and TIMEOUT at least 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [GW-1:0]     grant_next;
    logic [GW-1:0]     rr_ptr, rr_next;
    logic [GW-1:0]     pick_idx;
    logic              pick_found;
    logic              accept;
    logic [D_WIDTH-1:0] data_arr [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*D_WIDTH +: D_WIDTH];
    end

    // Index arithmetic is done in int and folded back modulo N so that
    // non-power-of-two N wraps correctly.
    function automatic logic [GW-1:0] wrap_idx(input int v);
        return GW'(v % N);
    endfunction

    // Round-robin pick: first valid requester after the one that finished
    // most recently, so a waiting requester is passed over at most N-1 times.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr;
        for (int k = 1; k <= N; k++) begin
            if (!pick_found && req_valid[wrap_idx(int'(rr_ptr) + k)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_idx(int'(rr_ptr) + k);
            end
        end
    end

    assign fifo_din = data_arr[grant_id];
    assign busy     = (state == XFER);

`ifdef FIFO_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] idle_cnt, idle_cnt_next;
    logic          revoke;
`endif

    // Next-state and handshake logic. A FIFO-full stall is not counted as
    // requester idleness, so the timeout only advances when the FIFO could
    // have taken a word but the granted requester had none.
    always_comb begin
        state_next = state;
        grant_next = grant_id;
        rr_next    = rr_ptr;
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        accept     = 1'b0;
`ifdef FIFO_ARB_TIMEOUT_EN
        idle_cnt_next = idle_cnt;
        revoke        = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next = XFER;
                    grant_next = pick_idx;
`ifdef FIFO_ARB_TIMEOUT_EN
                    idle_cnt_next = '0;
`endif
                end
            end
            XFER: begin
                req_ready[grant_id] = ~fifo_full;
                accept              = req_valid[grant_id] & ~fifo_full;
                fifo_wr_en          = accept;
                if (accept) begin
`ifdef FIFO_ARB_TIMEOUT_EN
                    idle_cnt_next = '0;
`endif
                    if (req_last[grant_id]) begin
                        state_next = IDLE;
                        rr_next    = grant_id;
                    end
                end
`ifdef FIFO_ARB_TIMEOUT_EN
                else if (!req_valid[grant_id] && !fifo_full) begin
                    if (idle_cnt >= CW'(TIMEOUT - 1)) begin
                        revoke        = 1'b1;
                        state_next    = IDLE;
                        rr_next       = grant_id;
                        idle_cnt_next = CW'(TIMEOUT);
                    end else begin
                        idle_cnt_next = idle_cnt + CW'(1);
                    end
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= GW'(N - 1);
        end else begin
            state    <= state_next;
            grant_id <= grant_next;
            rr_ptr   <= rr_next;
        end
    end

`ifdef FIFO_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            idle_cnt    <= idle_cnt_next;
            timeout_err <= revoke;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (N=4, D_WIDTH=16, TIMEOUT=8).
// Directed cycle vectors from a table, hand-written reset/timeout
// sequences, and a randomized run compared against a packet-level
// round-robin model of the expected FIFO contents.

module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_last;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic [DW-1:0]     fifo_din;
    logic              fifo_wr_en;
    logic              fifo_full;
    logic [1:0]        grant_id;
    logic              busy;
`ifdef FIFO_ARB_TIMEOUT_EN
    logic              timeout_err;
`endif

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(.N(N), .D_WIDTH(DW), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .grant_id   (grant_id),
        .busy       (busy)
`ifdef FIFO_ARB_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         pre_reset;
        logic [3:0] valid;
        logic [3:0] last;
        logic [15:0] data;
        logic       full;
        logic       exp_busy;
        logic [1:0] exp_grant;
        logic [3:0] exp_ready;
        logic       exp_wr;
        logic [15:0] exp_din;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic        last;
    } word_t;

    vec_t        tbl[$];
    word_t       src[N][$];
    word_t       mq[N][$];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    function automatic vec_t mk(bit pr, logic [3:0] v, logic [3:0] l, logic [15:0] d,
                                logic f, logic eb, logic [1:0] eg, logic [3:0] er,
                                logic ew, logic [15:0] ed);
        vec_t r;
        r.pre_reset = pr; r.valid = v; r.last = l; r.data = d; r.full = f;
        r.exp_busy = eb; r.exp_grant = eg; r.exp_ready = er; r.exp_wr = ew; r.exp_din = ed;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slices without valid carry a distinct filler so a wrong mux select shows up.
    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l,
                                 input logic [15:0] d, input logic f);
        req_valid = v;
        req_last  = l;
        fifo_full = f;
        for (int i = 0; i < N; i++)
            req_data[i*DW +: DW] = v[i] ? d : (16'hBAD0 | 16'(i));
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 16'h0000, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Packet-level reference: the FIFO must contain whole packets, picked
    // round-robin starting after requester N-1, each producer in its own order.
    function automatic void build_expected();
        int    last_w;
        int    p;
        bit    any;
        bit    done;
        word_t w;
        last_w = N - 1;
        for (int i = 0; i < N; i++) mq[i] = src[i];
        do begin
            any = 1'b0;
            for (int k = 1; k <= N && !any; k++) begin
                p = (last_w + k) % N;
                if (mq[p].size() > 0) begin
                    done = 1'b0;
                    while (!done) begin
                        w = mq[p].pop_front();
                        exp_q.push_back(w.d);
                        done = w.last;
                    end
                    last_w = p;
                    any    = 1'b1;
                end
            end
        end while (any);
    endfunction

    initial begin
        vec_t        r;
        int          cycles;
        int          n_busy;
        int          total;
        logic [N-1:0] acc;
        bit          midpkt[N];
        bit          prev_bub[N];
        bit          bub;
        int          npk;
        int          len;

        doReset();

        // Reset state held with no requests.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput($sformatf("idle%0d_busy", c), busy, 0);
            checkOutput($sformatf("idle%0d_wr_en", c), fifo_wr_en, 0);
            checkOutput($sformatf("idle%0d_ready", c), req_ready, 0);
`ifdef FIFO_ARB_TIMEOUT_EN
            checkOutput($sformatf("idle%0d_timeout_err", c), timeout_err, 0);
`endif
            @(posedge clk); #1;
        end
        checkOutput("reset_grant_id", grant_id, 0);

        // Requester 2 three-word packet.
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 16'h00A1, 0, 0, 0, 4'b0000, 0, 16'h0000));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 16'h00A1, 0, 1, 2, 4'b0100, 1, 16'h00A1));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 16'h00A2, 0, 1, 2, 4'b0100, 1, 16'h00A2));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 16'h00A3, 0, 1, 2, 4'b0100, 1, 16'h00A3));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 16'h0000, 0, 0, 2, 4'b0000, 0, 16'h0000));
        // All requesters, two-word packets: order 0,1,2,3,0.
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 16'h0B01, 0, 0, 0, 4'b0000, 0, 16'h0000));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h0B01, 0, 1, 0, 4'b0001, 1, 16'h0B01));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 16'h0B02, 0, 1, 0, 4'b0001, 1, 16'h0B02));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h0B03, 0, 0, 0, 4'b0000, 0, 16'h0000));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h0B03, 0, 1, 1, 4'b0010, 1, 16'h0B03));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 16'h0B04, 0, 1, 1, 4'b0010, 1, 16'h0B04));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h0B05, 0, 0, 1, 4'b0000, 0, 16'h0000));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h0B05, 0, 1, 2, 4'b0100, 1, 16'h0B05));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 16'h0B06, 0, 1, 2, 4'b0100, 1, 16'h0B06));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h0B07, 0, 0, 2, 4'b0000, 0, 16'h0000));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h0B07, 0, 1, 3, 4'b1000, 1, 16'h0B07));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 16'h0B08, 0, 1, 3, 4'b1000, 1, 16'h0B08));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h0B09, 0, 0, 3, 4'b0000, 0, 16'h0000));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h0B09, 0, 1, 0, 4'b0001, 1, 16'h0B09));
        // FIFO full for five cycles mid-packet, then the last word goes through once.
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h0B0A, 1, 1, 0, 4'b0000, 0, 16'h0000));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 16'h0B0A, 0, 1, 0, 4'b0001, 1, 16'h0B0A));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 16'h0000, 0, 0, 0, 4'b0000, 0, 16'h0000));
        // Single-word packet, then last without valid in IDLE and in XFER.
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 16'h00C1, 0, 0, 0, 4'b0000, 0, 16'h0000));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 16'h00C1, 0, 1, 2, 4'b0100, 1, 16'h00C1));
        tbl.push_back(mk(0, 4'b0000, 4'b0100, 16'h0000, 0, 0, 2, 4'b0000, 0, 16'h0000));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 16'h00D1, 0, 0, 2, 4'b0000, 0, 16'h0000));
        tbl.push_back(mk(0, 4'b0000, 4'b0010, 16'h00D2, 0, 1, 1, 4'b0010, 0, 16'h0000));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 16'h00D2, 0, 1, 1, 4'b0010, 1, 16'h00D2));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 16'h0000, 0, 0, 1, 4'b0000, 0, 16'h0000));

        for (int k = 0; k < tbl.size(); k++) begin
            r = tbl[k];
            if (r.pre_reset) doReset();
            applyStimulus(r.valid, r.last, r.data, r.full);
            @(negedge clk);
            checkOutput($sformatf("row%0d_busy", k), busy, r.exp_busy);
            checkOutput($sformatf("row%0d_grant_id", k), grant_id, r.exp_grant);
            checkOutput($sformatf("row%0d_ready", k), req_ready, r.exp_ready);
            checkOutput($sformatf("row%0d_wr_en", k), fifo_wr_en, r.exp_wr);
            if (r.exp_wr) checkOutput($sformatf("row%0d_din", k), fifo_din, r.exp_din);
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of a packet.
        doReset();
        applyStimulus(4'b0010, 4'b0000, 16'h00E1, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("async_pre_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_busy", busy, 0);
        checkOutput("async_ready", req_ready, 0);
        checkOutput("async_wr_en", fifo_wr_en, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        applyStimulus(4'b1111, 4'b0000, 16'h00E2, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("after_reset_grant", grant_id, 0);
        checkOutput("after_reset_ready", req_ready, 4'b0001);
        @(posedge clk); #1;

`ifdef FIFO_ARB_TIMEOUT_EN
        // Requester 1 stalls after one word; grant revoked after 8 idle cycles.
        doReset();
        applyStimulus(4'b0010, 4'b0000, 16'h00F1, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("to_first_word", fifo_wr_en, 1);
        @(posedge clk); #1;
        applyStimulus(4'b0100, 4'b0000, 16'h00F2, 0);
        @(negedge clk);
        cycles = 0;
        n_busy = 0;
        while (!timeout_err && cycles < 40) begin
            if (busy) n_busy++;
            cycles++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        checkOutput("to_pulse_seen", timeout_err, 1);
        checkOutput("to_idle_cycles", n_busy, 8);
        checkOutput("to_busy_dropped", busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("to_pulse_width", timeout_err, 0);
        checkOutput("to_next_grant", grant_id, 2);
        checkOutput("to_next_busy", busy, 1);
        @(posedge clk); #1;
`endif

        // Randomized packets from all producers against the packet-level model.
        doReset();
        for (int i = 0; i < N; i++) begin
            npk = $urandom_range(1, 4);
            for (int p = 0; p < npk; p++) begin
                len = $urandom_range(1, 4);
                for (int w = 0; w < len; w++)
                    src[i].push_back('{d: {4'(i), 12'($urandom)}, last: (w == len - 1)});
            end
            midpkt[i]   = 1'b0;
            prev_bub[i] = 1'b0;
        end
        build_expected();

        cycles = 0;
        total  = 0;
        for (int i = 0; i < N; i++) total += src[i].size();
        while (total > 0 && cycles < 3000) begin
            for (int i = 0; i < N; i++) begin
                if (src[i].size() > 0) begin
                    bub          = midpkt[i] && !prev_bub[i] && ($urandom_range(0, 3) == 0);
                    req_valid[i] = !bub;
                    req_last[i]  = src[i][0].last;
                    req_data[i*DW +: DW] = src[i][0].d;
                end else begin
                    bub          = 1'b0;
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'($urandom_range(0, 1));
                    req_data[i*DW +: DW] = 16'($urandom);
                end
                prev_bub[i] = bub;
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            acc = req_valid & req_ready;
            checkOutput("rand_ready_onehot", ($countones(req_ready) > 1), 0);
            checkOutput("rand_no_write_when_full", fifo_wr_en & fifo_full, 0);
            checkOutput("rand_wr_en_matches_handshake", fifo_wr_en, |acc);
            if (fifo_wr_en) got_q.push_back(fifo_din);
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    midpkt[i] = !src[i][0].last;
                    void'(src[i].pop_front());
                    total--;
                end
            end
            cycles++;
        end
        checkOutput("rand_drain_timeout", (total > 0), 0);
        checkOutput("rand_word_count", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < got_q.size())
                checkOutput($sformatf("rand_word%0d", k), got_q[k], exp_q[k]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
